// File: rtl/lcd_write_engine.sv
`default_nettype none
// ============================================================================
// Module   : lcd_write_engine
// Purpose  : HD44780-style write-cycle generator. Accepts one byte plus RS
//            flag per valid/ready handshake, then drives setup, EN pulse,
//            hold and the execution wait on the LCD pins.
// Options  : LCD_INIT_SEQ_EN - power-on delay plus a six-write init sequence
//            (function set x3, display on, clear, entry mode).
// Revision : 1.0 - initial release
// ============================================================================
module lcd_write_engine #(
  parameter int unsigned SETUP_CYC      = 3,
  parameter int unsigned EN_CYC         = 12,
  parameter int unsigned HOLD_CYC       = 2,
  parameter int unsigned SHORT_WAIT_CYC = 2000,
  parameter int unsigned LONG_WAIT_CYC  = 82000,
  parameter int unsigned POWERUP_CYC    = 750000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_rs_i,
  input  logic [7:0]  req_data_i,
  output logic        busy_o,
  output logic        init_done_o,
  output logic [15:0] wr_count_o,
  output logic        lcd_on_o,
  output logic        lcd_en_o,
  output logic        lcd_rs_o,
  output logic        lcd_rw_o,
  output logic [7:0]  lcd_data_o
);

  // Shared down-counter sized for the longest interval, never below 17 bits.
  localparam int unsigned MAX_WAIT = (LONG_WAIT_CYC > POWERUP_CYC) ? LONG_WAIT_CYC : POWERUP_CYC;
  localparam int unsigned CNT_W    = ($clog2(MAX_WAIT + 1) > 17) ? $clog2(MAX_WAIT + 1) : 17;

  localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] LD_EN    = CNT_W'(EN_CYC - 1);
  localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] LD_SHORT = CNT_W'(SHORT_WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] LD_LONG  = CNT_W'(LONG_WAIT_CYC - 1);

  localparam logic [2:0] ST_RST   = 3'd0;
  localparam logic [2:0] ST_IDLE  = 3'd1;
  localparam logic [2:0] ST_SETUP = 3'd2;
  localparam logic [2:0] ST_PULSE = 3'd3;
  localparam logic [2:0] ST_HOLD  = 3'd4;
  localparam logic [2:0] ST_WAIT  = 3'd5;
`ifdef LCD_INIT_SEQ_EN
  localparam logic [2:0] ST_PWRUP = 3'd6;
  localparam logic [CNT_W-1:0] LD_PWRUP = CNT_W'(POWERUP_CYC - 1);
`endif

  // Clear-display (0x01) and return-home (0x02/0x03) need the long wait.
  function automatic logic f_long(input logic rs, input logic [7:0] d);
    return (rs == 1'b0) && ((d[7:1] == 7'b0000000) || (d[7:1] == 7'b0000001));
  endfunction

`ifdef LCD_INIT_SEQ_EN
  function automatic logic [7:0] f_init_byte(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd1, 3'd2: return 8'h38;
      3'd3:             return 8'h0C;
      3'd4:             return 8'h01;
      default:          return 8'h06;
    endcase
  endfunction
`endif

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rst_dly_q;
  logic             ready_q, ready_d;
  logic             en_q, en_d;
  logic             on_q, on_d;
  logic             init_done_q, init_done_d;
  logic             rs_q, rs_d;
  logic [7:0]       data_q, data_d;
  logic             long_q, long_d;
  logic [15:0]      wr_cnt_q, wr_cnt_d;
`ifdef LCD_INIT_SEQ_EN
  logic             init_act_q, init_act_d;
  logic [2:0]       init_idx_q, init_idx_d;
`endif

  logic accept;
  logic cnt_zero;
  assign accept   = (state_q == ST_IDLE) && ready_q && req_valid_i;
  assign cnt_zero = (cnt_q == '0);

  // State register: FSM state, shared counter, reset-release delay flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_RST;
      cnt_q      <= '0;
      rst_dly_q  <= 1'b0;
`ifdef LCD_INIT_SEQ_EN
      init_act_q <= 1'b0;
      init_idx_q <= 3'd0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rst_dly_q  <= 1'b1;
`ifdef LCD_INIT_SEQ_EN
      init_act_q <= init_act_d;
      init_idx_q <= init_idx_d;
`endif
    end
  end

  // Next-state logic: each phase loads the counter on entry and exits at zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_zero ? '0 : cnt_q - CNT_W'(1);
    case (state_q)
      ST_RST: begin
        cnt_d = '0;
        if (rst_dly_q) begin
`ifdef LCD_INIT_SEQ_EN
          state_d = ST_PWRUP;
          cnt_d   = LD_PWRUP;
`else
          state_d = ST_IDLE;
`endif
        end
      end
`ifdef LCD_INIT_SEQ_EN
      ST_PWRUP: if (cnt_zero) begin state_d = ST_SETUP; cnt_d = LD_SETUP; end
`endif
      ST_IDLE:  if (accept)   begin state_d = ST_SETUP; cnt_d = LD_SETUP; end
      ST_SETUP: if (cnt_zero) begin state_d = ST_PULSE; cnt_d = LD_EN;    end
      ST_PULSE: if (cnt_zero) begin state_d = ST_HOLD;  cnt_d = LD_HOLD;  end
      ST_HOLD:  if (cnt_zero) begin state_d = ST_WAIT;  cnt_d = long_q ? LD_LONG : LD_SHORT; end
      ST_WAIT: begin
        if (cnt_zero) begin
          state_d = ST_IDLE;
`ifdef LCD_INIT_SEQ_EN
          if (init_act_q && (init_idx_q != 3'd5)) begin
            state_d = ST_SETUP;
            cnt_d   = LD_SETUP;
          end
`endif
        end
      end
      default: begin state_d = ST_RST; cnt_d = '0; end
    endcase
  end

  // Output logic: pin/handshake values for the coming state, write capture.
  always_comb begin
    ready_d     = (state_d == ST_IDLE);
    en_d        = (state_d == ST_PULSE);
    on_d        = (state_d != ST_RST);
    init_done_d = init_done_q || (state_d == ST_IDLE);
    rs_d        = rs_q;
    data_d      = data_q;
    long_d      = long_q;
    wr_cnt_d    = wr_cnt_q;
`ifdef LCD_INIT_SEQ_EN
    init_act_d  = init_act_q;
    init_idx_d  = init_idx_q;
    if ((state_q == ST_PWRUP) && cnt_zero) begin
      init_act_d = 1'b1;
      init_idx_d = 3'd0;
      rs_d       = 1'b0;
      data_d     = f_init_byte(3'd0);
      long_d     = f_long(1'b0, f_init_byte(3'd0));
    end
    if ((state_q == ST_WAIT) && cnt_zero && init_act_q) begin
      if (init_idx_q == 3'd5) begin
        init_act_d = 1'b0;
      end else begin
        init_idx_d = init_idx_q + 3'd1;
        rs_d       = 1'b0;
        data_d     = f_init_byte(init_idx_q + 3'd1);
        long_d     = f_long(1'b0, f_init_byte(init_idx_q + 3'd1));
      end
    end
`endif
    if (accept) begin
      rs_d     = req_rs_i;
      data_d   = req_data_i;
      long_d   = f_long(req_rs_i, req_data_i);
      wr_cnt_d = wr_cnt_q + 16'd1;
    end
  end

  // Output registers: every pin and status output comes straight from a flop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ready_q     <= 1'b0;
      en_q        <= 1'b0;
      on_q        <= 1'b0;
      init_done_q <= 1'b0;
      rs_q        <= 1'b0;
      data_q      <= 8'h00;
      long_q      <= 1'b0;
      wr_cnt_q    <= 16'd0;
    end else begin
      ready_q     <= ready_d;
      en_q        <= en_d;
      on_q        <= on_d;
      init_done_q <= init_done_d;
      rs_q        <= rs_d;
      data_q      <= data_d;
      long_q      <= long_d;
      wr_cnt_q    <= wr_cnt_d;
    end
  end

  assign req_ready_o = ready_q;
  assign busy_o      = ~ready_q;
  assign init_done_o = init_done_q;
  assign wr_count_o  = wr_cnt_q;
  assign lcd_on_o    = on_q;
  assign lcd_en_o    = en_q;
  assign lcd_rs_o    = rs_q;
  assign lcd_rw_o    = 1'b0;
  assign lcd_data_o  = data_q;

endmodule
`default_nettype wire

// File: tb/tb_lcd_write_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd_write_engine
// Purpose  : Self-checking bench for lcd_write_engine with random writes
//            checked against a cycle-budget reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lcd_write_engine;

  localparam int S  = 2;
  localparam int E  = 4;
  localparam int H  = 1;
  localparam int SH = 10;
  localparam int L  = 50;
  localparam int PU = 100;
`ifdef LCD_INIT_SEQ_EN
  localparam int BRINGUP = 2 + PU + 5 * (S + E + H + SH) + (S + E + H + L);
`else
  localparam int BRINGUP = 2;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_rs = 1'b0;
  logic [7:0]  req_data = 8'h00;
  logic        req_ready, busy, init_done, lcd_on, lcd_en, lcd_rs, lcd_rw;
  logic [15:0] wr_count;
  logic [7:0]  lcd_data;

  int total = 0;
  int bad = 0;
  int model_cnt = 0;
  int pulses = 0;
  int rw_bad = 0;
  logic en_prev = 1'b0;
  logic [8:0] pulse_q[$];

  always #5 clk = ~clk;

  lcd_write_engine #(
    .SETUP_CYC(S), .EN_CYC(E), .HOLD_CYC(H),
    .SHORT_WAIT_CYC(SH), .LONG_WAIT_CYC(L), .POWERUP_CYC(PU)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_rs_i(req_rs), .req_data_i(req_data),
    .busy_o(busy), .init_done_o(init_done), .wr_count_o(wr_count),
    .lcd_on_o(lcd_on), .lcd_en_o(lcd_en), .lcd_rs_o(lcd_rs),
    .lcd_rw_o(lcd_rw), .lcd_data_o(lcd_data)
  );

  // Pin monitor: log every EN pulse with the RS/DATA it carried; watch R/W.
  always @(negedge clk) begin
    if (lcd_en && !en_prev) begin
      pulses = pulses + 1;
      pulse_q.push_back({lcd_rs, lcd_data});
    end
    en_prev = lcd_en;
    if (lcd_rw !== 1'b0) rw_bad = rw_bad + 1;
  end

  // Reference: full write cycle length from the command-class rule.
  function automatic int exp_lat(input logic rs, input logic [7:0] d);
    int w;
    w = (!rs && (d < 8'd4)) ? L : SH;
    return S + E + H + w;
  endfunction

  // Release reset on a falling edge and count rising edges until ready.
  task automatic bring_up(output int n);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    forever begin
      @(posedge clk);
      n++;
      #1;
      if (req_ready || n > 2000) break;
    end
  endtask

  // Wait (bounded) until ready, then let the next rising edge accept.
  task automatic wait_accept(output bit ok);
    int n;
    n = 0;
    while (!req_ready && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    ok = req_ready;
    @(posedge clk);
  endtask

  // Observe one write cycle starting right after its accept edge.
  task automatic measure(input bit keep, input int sw_cyc, input logic [7:0] sw_data,
                         output int rise, output int len, output int lat,
                         output logic [8:0] seen);
    rise = -1; len = 0; lat = 0; seen = '0;
    #1;
    if (!keep) req_valid = 1'b0;
    forever begin
      @(posedge clk);
      lat++;
      #1;
      if (lcd_en) begin
        if (rise < 0) begin rise = lat; seen = {lcd_rs, lcd_data}; end
        len++;
      end
      if (lat == sw_cyc) req_data = sw_data;
      if (req_ready || lat > 1000) break;
    end
  endtask

  task automatic do_write(input logic rs, input logic [7:0] d, output bit ok,
                          output int rise, output int len, output int lat,
                          output logic [8:0] seen);
    req_rs = rs; req_data = d; req_valid = 1'b1;
    wait_accept(ok);
    if (ok) model_cnt = (model_cnt + 1) % 65536;
    measure(1'b0, -1, 8'h00, rise, len, lat, seen);
  endtask

  task automatic test_reset;
    int n;
    rst_n = 1'b0;
    pulse_q.delete();
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({req_ready, busy, lcd_en, lcd_rs, lcd_rw, lcd_data, lcd_on, wr_count, init_done} !==
        {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0}) begin
      bad++;
      $display("FAIL reset_values: got rdy=%b busy=%b en=%b rs=%b rw=%b data=%h on=%b cnt=%0d done=%b, want all zero except busy=1",
               req_ready, busy, lcd_en, lcd_rs, lcd_rw, lcd_data, lcd_on, wr_count, init_done);
    end
    bring_up(n);
    total++;
    if (n !== BRINGUP) begin bad++; $display("FAIL bringup_latency: got %0d want %0d", n, BRINGUP); end
    total++;
    if ({lcd_on, init_done, busy, wr_count} !== {1'b1, 1'b1, 1'b0, 16'h0000}) begin
      bad++;
      $display("FAIL post_reset_status: got on=%b done=%b busy=%b cnt=%0d want 1 1 0 0", lcd_on, init_done, busy, wr_count);
    end
`ifdef LCD_INIT_SEQ_EN
    begin
      logic [8:0] exp_seq[6];
      exp_seq = '{9'h038, 9'h038, 9'h038, 9'h00C, 9'h001, 9'h006};
      total++;
      if (pulse_q.size() != 6) begin bad++; $display("FAIL init_pulse_count: got %0d want 6", pulse_q.size()); end
      for (int i = 0; i < 6 && i < pulse_q.size(); i++) begin
        total++;
        if (pulse_q[i] !== exp_seq[i]) begin
          bad++;
          $display("FAIL init_byte%0d: got %h want %h", i, pulse_q[i], exp_seq[i]);
        end
      end
    end
`endif
    model_cnt = 0;
  endtask

  task automatic test_data_write;
    bit ok; int rise, len, lat; logic [8:0] seen;
    do_write(1'b1, 8'h41, ok, rise, len, lat, seen);
    total++;
    if (!ok || rise !== S || len !== E) begin
      bad++;
      $display("FAIL data_en_timing: got ok=%b rise=%0d len=%0d want 1 %0d %0d", ok, rise, len, S, E);
    end
    total++;
    if (seen !== {1'b1, 8'h41}) begin bad++; $display("FAIL data_pins: got %h want 141", seen); end
    total++;
    if (lat !== 17) begin bad++; $display("FAIL data_latency: got %0d want 17", lat); end
    total++;
    if (wr_count !== 16'(model_cnt)) begin bad++; $display("FAIL data_count: got %0d want %0d", wr_count, model_cnt); end
  endtask

  task automatic test_long_wait;
    logic [8:0] vecs[5];
    bit ok; int rise, len, lat; logic [8:0] seen;
    vecs = '{9'h001, 9'h003, 9'h004, 9'h002, 9'h101};
    for (int i = 0; i < 5; i++) begin
      do_write(vecs[i][8], vecs[i][7:0], ok, rise, len, lat, seen);
      total++;
      if (!ok || lat !== exp_lat(vecs[i][8], vecs[i][7:0])) begin
        bad++;
        $display("FAIL wait_len_%h: got %0d want %0d", vecs[i], lat, exp_lat(vecs[i][8], vecs[i][7:0]));
      end
    end
  endtask

  task automatic test_random;
    bit ok; int rise, len, lat, p0; logic [8:0] seen;
    logic rs; logic [7:0] d;
    for (int i = 0; i < 16; i++) begin
      rs = 1'($urandom);
      d  = 8'($urandom);
      if (i % 4 == 0) d = 8'($urandom_range(1, 3));
      if (!rs && d == 8'h00) d = 8'h01;
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      p0 = pulses;
      do_write(rs, d, ok, rise, len, lat, seen);
      total++;
      if (!ok || rise !== S || len !== E || lat !== exp_lat(rs, d) || seen !== {rs, d} ||
          wr_count !== 16'(model_cnt) || pulses - p0 !== 1) begin
        bad++;
        $display("FAIL random_%0d: got rise=%0d len=%0d lat=%0d pins=%h cnt=%0d pulses=%0d want %0d %0d %0d %h %0d 1",
                 i, rise, len, lat, seen, wr_count, pulses - p0, S, E, exp_lat(rs, d), {rs, d}, model_cnt);
      end
    end
  endtask

  task automatic test_back_to_back;
    bit ok; int rise, len, lat, p0; logic [8:0] seen;
    p0 = pulses;
    req_rs = 1'b1; req_data = 8'h20; req_valid = 1'b1;
    wait_accept(ok);
    model_cnt = (model_cnt + 1) % 65536;
    #1;
    req_data = 8'h55;
    measure(1'b1, 12, 8'h66, rise, len, lat, seen);
    total++;
    if (seen !== {1'b1, 8'h20} || lcd_data !== 8'h20) begin
      bad++;
      $display("FAIL busy_ignored: got pins=%h hold=%h want 120 20", seen, lcd_data);
    end
    wait_accept(ok);
    model_cnt = (model_cnt + 1) % 65536;
    measure(1'b0, -1, 8'h00, rise, len, lat, seen);
    total++;
    if (seen !== {1'b1, 8'h66} || lat !== 17) begin
      bad++;
      $display("FAIL held_request: got pins=%h lat=%0d want 166 17", seen, lat);
    end
    total++;
    if (pulses - p0 !== 2 || wr_count !== 16'(model_cnt)) begin
      bad++;
      $display("FAIL one_pulse_per_accept: got pulses=%0d cnt=%0d want 2 %0d", pulses - p0, wr_count, model_cnt);
    end
    total++;
    if (rw_bad !== 0) begin bad++; $display("FAIL rw_low: got %0d cycles with rw=1 want 0", rw_bad); end
  endtask

  task automatic test_wrap;
    bit ok; int rise, len, lat; logic [8:0] seen;
    force dut.wr_cnt_q = 16'hFFFF;
    #2;
    release dut.wr_cnt_q;
    model_cnt = 65535;
    do_write(1'b1, 8'h7A, ok, rise, len, lat, seen);
    total++;
    if (wr_count !== 16'(model_cnt) || wr_count !== 16'h0000) begin
      bad++;
      $display("FAIL count_wrap: got %0d want %0d", wr_count, model_cnt);
    end
  endtask

  task automatic test_reset_mid_pulse;
    bit ok; int n, rise, len, lat; logic [8:0] seen;
    req_rs = 1'b1; req_data = 8'h41; req_valid = 1'b1;
    wait_accept(ok);
    #1;
    req_valid = 1'b0;
    n = 0;
    while (!lcd_en && n < 50) begin @(posedge clk); #1; n++; end
    total++;
    if (lcd_en !== 1'b1) begin bad++; $display("FAIL pulse_reached: got en=%b want 1", lcd_en); end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({lcd_en, req_ready, lcd_rs, lcd_data, lcd_on, wr_count, init_done} !==
        {1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0}) begin
      bad++;
      $display("FAIL async_reset: got en=%b rdy=%b rs=%b data=%h on=%b cnt=%0d done=%b want all zero",
               lcd_en, req_ready, lcd_rs, lcd_data, lcd_on, wr_count, init_done);
    end
    model_cnt = 0;
    repeat (2) @(posedge clk);
    bring_up(n);
    total++;
    if (n !== BRINGUP) begin bad++; $display("FAIL rerelease_latency: got %0d want %0d", n, BRINGUP); end
    do_write(1'b1, 8'h42, ok, rise, len, lat, seen);
    total++;
    if (!ok || wr_count !== 16'(model_cnt) || seen !== {1'b1, 8'h42}) begin
      bad++;
      $display("FAIL after_reset_write: got cnt=%0d pins=%h want %0d 142", wr_count, seen, model_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_data_write();
    test_long_wait();
    test_random();
    test_back_to_back();
    test_wrap();
    test_reset_mid_pulse();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
